// File: rtl/icache_param_if.sv
// Fetch, TLB, flush and interconnect signals of the parametrised instruction cache.
// The cache connects through the slave view; the fetch unit and bus model use the master view.
interface icache_param_if #(
    parameter int IDATAW   = 128,
    parameter int IADDRW   = 32,
    parameter int BUSDATAW = 32,
    parameter int BUSADDRW = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [IADDRW-1:0]   req_address;
    logic [IADDRW-1:0]   phys_addr;
    logic                tlb_hit;
    logic                dp_valid;
    logic                dp_ready;
    logic [IDATAW-1:0]   dp_read_data;
    logic                flush;
    logic                flush_done;
    logic [BUSADDRW-1:0] mem_addr;
    logic                mem_req;
    logic                mem_data_valid;
    logic [BUSDATAW-1:0] mem_data;
    logic                mem_rd_wr;
    logic                mem_en;
    logic                mem_done;
    logic                grant_in;
    logic                grant_out;
    logic                bus_busy_in;
    logic                bus_busy_out;

    modport slave (
        input  req_valid, req_address, phys_addr, tlb_hit, dp_ready, flush,
               mem_data_valid, mem_data, grant_in, bus_busy_in,
        output req_ready, dp_valid, dp_read_data, flush_done, mem_addr, mem_req,
               mem_rd_wr, mem_en, mem_done, grant_out, bus_busy_out
    );

    modport master (
        output req_valid, req_address, phys_addr, tlb_hit, dp_ready, flush,
               mem_data_valid, mem_data, grant_in, bus_busy_in,
        input  req_ready, dp_valid, dp_read_data, flush_done, mem_addr, mem_req,
               mem_rd_wr, mem_en, mem_done, grant_out, bus_busy_out
    );
endinterface

// File: rtl/icache_param.sv
// Direct-mapped, physically-tagged instruction cache with burst line fill, whole-cache
// flush and TLB-miss stall. Defining ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_param #(
    parameter int IDATAW   = 128,
    parameter int IADDRW   = 32,
    parameter int BUSDATAW = 32,
    parameter int BUSADDRW = 32,
    parameter int NUM_SETS = 32,
    parameter int IDXW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    icache_param_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
`endif
);
    localparam int OFFW       = $clog2(IDATAW / 8);
    localparam int BEATS      = IDATAW / BUSDATAW;
    localparam int TAGW       = IADDRW - IDXW - OFFW;
    localparam int BEATW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BYTES = BUSDATAW / 8;

    typedef enum logic [2:0] {IDLE, LOOKUP, TLBWAIT, ARB, FILL, WRITE, RESP, FLUSH} state_t;

    state_t              state, state_n;
    logic [NUM_SETS-1:0] valid;
    logic [TAGW-1:0]     tag_mem  [NUM_SETS];
    logic [IDATAW-1:0]   data_mem [NUM_SETS];
    logic [IDXW-1:0]     pa_idx, idx_q, flush_idx;
    logic [TAGW-1:0]     pa_tag, tag_q;
    logic [BEATW-1:0]    beat;
    logic [IDATAW-1:0]   fill_line, resp_line;
    logic                own, flush_pend;
    logic                lookup_en, lookup_hit, beat_en, last_beat;
    logic                unused_addr;

    assign pa_idx     = bus.phys_addr[OFFW+IDXW-1:OFFW];
    assign pa_tag     = bus.phys_addr[IADDRW-1:OFFW+IDXW];
    assign lookup_en  = ((state == LOOKUP) || (state == TLBWAIT)) && bus.tlb_hit;
    assign lookup_hit = valid[pa_idx] && (tag_mem[pa_idx] == pa_tag);
    assign beat_en    = (state == FILL) && bus.mem_data_valid;
    assign last_beat  = beat_en && (beat == BEATW'(BEATS - 1));

    // The virtual address only names the request; index and tag come from the translation.
    assign unused_addr = ^{bus.req_address, bus.phys_addr[OFFW-1:0]};

    assign bus.dp_read_data = resp_line;
    assign bus.mem_rd_wr    = 1'b0;
    assign bus.mem_en       = own;
    assign bus.bus_busy_out = own;
    assign bus.grant_out    = (bus.mem_req || own) ? 1'b0 : bus.grant_in;
    assign bus.mem_addr     = own ? (BUSADDRW'({tag_q, idx_q, {OFFW{1'b0}}})
                                     + BUSADDRW'(beat) * BUSADDRW'(BEAT_BYTES)) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n        = state;
        bus.req_ready  = 1'b0;
        bus.dp_valid   = 1'b0;
        bus.flush_done = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush || flush_pend) begin
                    state_n = FLUSH;
                end else begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) state_n = LOOKUP;
                end
            end
            LOOKUP, TLBWAIT: begin
                if (!bus.tlb_hit)    state_n = TLBWAIT;
                else if (lookup_hit) state_n = RESP;
                else                 state_n = ARB;
            end
            ARB: begin
                bus.mem_req = 1'b1;
                if (bus.grant_in && !bus.bus_busy_in) state_n = FILL;
            end
            FILL: begin
                if (last_beat) begin
                    bus.mem_done = 1'b1;
                    state_n      = WRITE;
                end
            end
            WRITE: state_n = RESP;
            RESP: begin
                bus.dp_valid = 1'b1;
                if (bus.dp_ready) state_n = IDLE;
            end
            FLUSH: begin
                if (flush_idx == IDXW'(NUM_SETS - 1)) begin
                    bus.flush_done = 1'b1;
                    state_n        = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid      <= '0;
            beat       <= '0;
            own        <= 1'b0;
            flush_pend <= 1'b0;
            flush_idx  <= '0;
            resp_line  <= '0;
        end else begin
            // A flush seen mid-transaction waits for the next return to IDLE.
            if (bus.flush && (state != IDLE) && (state != FLUSH)) flush_pend <= 1'b1;
            else if ((state == IDLE) && (state_n == FLUSH))       flush_pend <= 1'b0;

            if ((state == ARB) && (state_n == FILL)) own <= 1'b1;
            else if (last_beat)                      own <= 1'b0;

            if (beat_en) beat <= last_beat ? '0 : beat + 1'b1;

            if (state == FLUSH) begin
                valid[flush_idx] <= 1'b0;
                flush_idx        <= flush_idx + 1'b1;
            end
            if (state == WRITE) valid[idx_q] <= 1'b1;

            if (lookup_en && lookup_hit) resp_line <= data_mem[pa_idx];
            else if (state == WRITE)     resp_line <= fill_line;
        end
    end

    always_ff @(posedge clk) begin
        if (lookup_en && !lookup_hit) begin
            idx_q <= pa_idx;
            tag_q <= pa_tag;
        end
        if (beat_en) fill_line[int'(beat) * BUSDATAW +: BUSDATAW] <= bus.mem_data;
        if (state == WRITE) begin
            data_mem[idx_q] <= fill_line;
            tag_mem[idx_q]  <= tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (bus.flush_done) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (lookup_en) begin
            if (lookup_hit && (hit_count != 16'hFFFF))   hit_count  <= hit_count + 16'd1;
            if (!lookup_hit && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_param.sv
// Self-checking bench for icache_param: directed scenarios plus randomized accesses
// against a set/tag/valid model and a memory-content function.
`define CHK(n, o, e) chk(n, 128'(o), 128'(e))

module tb_icache_param;
    localparam int IDATAW = 128, IADDRW = 32, BUSDATAW = 32, BUSADDRW = 32;
    localparam int NUM_SETS = 32, IDXW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_param_if #(.IDATAW(IDATAW), .IADDRW(IADDRW), .BUSDATAW(BUSDATAW), .BUSADDRW(BUSADDRW)) bus ();

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    icache_param #(.IDATAW(IDATAW), .IADDRW(IADDRW), .BUSDATAW(BUSDATAW), .BUSADDRW(BUSADDRW),
                   .NUM_SETS(NUM_SETS), .IDXW(IDXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int           checks = 0;
    int           errors = 0;
    int           m_hits = 0;
    int           m_misses = 0;
    logic         m_valid [NUM_SETS];
    logic [22:0]  m_tag   [NUM_SETS];
    logic [127:0] last_data;
    logic [31:0]  ra;
    bit           owned;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h1230 && a <= 32'h123C) return {8{4'(((a - 32'h1230) >> 2) + 1)}};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] pa);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = mem_word({pa[31:4], 4'h0} + 32'(k * 4));
        return l;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NUM_SETS; k++) m_valid[k] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Entered in the cycle where the cache sits in IDLE with a flush requested.
    task automatic wait_flush();
        bit done;
        int off;
        done = 1'b0;
        off  = 0;
        `CHK("flush_blocks_req", bus.req_ready, 0);
        for (int i = 1; i <= 40; i++) begin
            cyc();
            bus.flush = 1'b0;
            bus.req_valid = 1'b0;
            #1;
            if (bus.flush_done) begin
                done = 1'b1;
                off  = i;
                break;
            end
            `CHK("flush_ready_low", bus.req_ready, 0);
        end
        `CHK("flush_done_seen", done, 1);
        `CHK("flush_length", off, NUM_SETS);
        cyc();
        #1;
        `CHK("flush_done_pulse", bus.flush_done, 0);
        `CHK("flush_back_idle", bus.req_ready, 1);
        model_clear();
    endtask

    task automatic access(input logic [31:0] pa, input int tlb_wait, input int busy_cyc,
                          input int bp_cyc, input bit flush_mid);
        logic [4:0]   idx;
        logic [22:0]  tg;
        logic [31:0]  base;
        logic [127:0] exp_line;
        bit           exp_hit, seen_req, got, prev_done;
        int           lat, beats, arb_cyc, busy_left;
        idx = pa[8:4];
        tg  = pa[31:9];
        base = {pa[31:4], 4'h0};
        exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
        exp_line = mem_line(pa);
        seen_req = 0; got = 0; prev_done = 0;
        beats = 0; arb_cyc = 0; busy_left = busy_cyc; lat = 1 + tlb_wait;

        cyc();
        bus.req_valid   = 1'b1;
        bus.req_address = pa ^ 32'hC000_0000;
        bus.phys_addr   = pa;
        bus.tlb_hit     = (tlb_wait == 0);
        bus.dp_ready    = 1'b0;
        #1;
        `CHK("req_ready", bus.req_ready, 1);
        `CHK("idle_grant", bus.grant_out, bus.grant_in);

        for (int i = 0; i < tlb_wait; i++) begin
            cyc();
            bus.req_valid = 1'b0;
            bus.tlb_hit   = 1'b0;
            bus.phys_addr = $urandom;
            #1;
            `CHK("tlbwait_quiet", bus.mem_req | bus.bus_busy_out | bus.dp_valid, 0);
        end

        for (int n = 0; n < 300; n++) begin
            cyc();
            bus.req_valid   = 1'b0;
            bus.phys_addr   = pa;
            bus.tlb_hit     = 1'b1;
            bus.bus_busy_in = (busy_left > 0);
            bus.flush       = flush_mid && (beats == 1);
            bus.mem_data_valid = bus.bus_busy_out && ($urandom_range(0, 2) != 0);
            bus.mem_data    = bus.mem_data_valid ? mem_word(base + 32'(4 * beats)) : $urandom;
            #1;
            if (prev_done) `CHK("fill_release", bus.bus_busy_out | bus.mem_en, 0);
            prev_done = 0;
            if (bus.mem_req) begin
                arb_cyc++;
                seen_req = 1;
                `CHK("arb_grant_out", bus.grant_out, 0);
                if (busy_left > 0) busy_left--;
            end
            if (bus.bus_busy_out) begin
                checks++;
                if (bus.mem_addr !== (base + 32'(4 * beats))) begin
                    errors++;
                    $error("FAIL fill_addr_beat observed=%0h expected=%0h", bus.mem_addr,
                           base + 32'(4 * beats));
                end
                `CHK("fill_addr", bus.mem_addr, base + 32'(4 * beats));
                `CHK("fill_en", bus.mem_en, 1);
                `CHK("fill_rd", bus.mem_rd_wr, 0);
                `CHK("fill_grant_out", bus.grant_out, 0);
                `CHK("fill_done", bus.mem_done, bus.mem_data_valid && (beats == 3));
                if (bus.mem_data_valid) begin
                    prev_done = (beats == 3);
                    beats++;
                end
            end
            if (bus.dp_valid) begin
                got = 1;
                break;
            end
            lat++;
        end
        bus.flush = 1'b0;
        bus.mem_data_valid = 1'b0;
        bus.bus_busy_in = 1'b0;

        `CHK("resp_seen", got, 1);
        `CHK("miss_path", seen_req, !exp_hit);
        if (exp_hit) begin
            `CHK("hit_latency", lat, 2 + tlb_wait);
        end else begin
            `CHK("beat_count", beats, 4);
            `CHK("arb_cycles", arb_cyc, busy_cyc + 1);
        end
        `CHK("resp_data", bus.dp_read_data, exp_line);
        last_data = bus.dp_read_data;

        for (int i = 0; i < bp_cyc; i++) begin
            cyc();
            bus.dp_ready = 1'b0;
            #1;
            `CHK("bp_valid", bus.dp_valid, 1);
            `CHK("bp_data", bus.dp_read_data, exp_line);
            checks++;
            if (bus.dp_read_data !== last_data) begin
                errors++;
                $error("FAIL bp_hold observed=%0h expected=%0h", bus.dp_read_data, last_data);
            end
        end
        cyc();
        bus.dp_ready = 1'b1;
        #1;
        `CHK("resp_accept", bus.dp_valid, 1);
        cyc();
        bus.dp_ready = 1'b0;
        #1;
        `CHK("resp_release", bus.dp_valid, 0);

        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (exp_hit) m_hits++;
        else         m_misses++;
        if (flush_mid) wait_flush();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_address = '0; bus.phys_addr = '0; bus.tlb_hit = 1'b0;
        bus.dp_ready = 1'b0; bus.flush = 1'b0; bus.mem_data_valid = 1'b0; bus.mem_data = '0;
        bus.grant_in = 1'b1; bus.bus_busy_in = 1'b0;
        model_clear();

        repeat (3) cyc();
        #1;
        `CHK("rst_req_ready", bus.req_ready, 1);
        `CHK("rst_grant_pass1", bus.grant_out, 1);
        `CHK("rst_ctl_low", bus.dp_valid | bus.mem_req | bus.mem_en | bus.bus_busy_out
                            | bus.mem_done | bus.flush_done | bus.mem_rd_wr, 0);
        `CHK("rst_data", bus.dp_read_data, 0);
        `CHK("rst_addr", bus.mem_addr, 0);
        bus.grant_in = 1'b0;
        #1;
        `CHK("rst_grant_pass0", bus.grant_out, 0);
        bus.grant_in = 1'b1;
        cyc();
        reset = 1'b1;

        access(32'h0000_1230, 0, 0, 0, 0);
        `CHK("cold_line", last_data, 128'h44444444_33333333_22222222_11111111);
        access(32'h0000_1230, 0, 0, 0, 0);
        access(32'h0000_0230, 0, 0, 0, 0);
        access(32'h0000_1230, 0, 0, 0, 0);
        access(32'h0000_4450, 0, 5, 0, 0);
        access(32'h0000_8880, 0, 0, 1, 1);
        access(32'h0000_1230, 0, 0, 0, 0);
        access(32'h0000_1230, 3, 0, 4, 0);
        access(32'h0000_5670, 2, 1, 3, 0);

        cyc();
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.phys_addr = 32'h0000_1230;
        bus.tlb_hit = 1'b1;
        #1;
        wait_flush();
        access(32'h0000_5670, 0, 0, 0, 0);

        for (int r = 0; r < 40; r++) begin
            ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4);
            access(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), 0);
        end

        cyc();
        bus.req_valid = 1'b1;
        bus.req_address = 32'h4000_2340;
        bus.phys_addr = 32'h0000_2340;
        bus.tlb_hit = 1'b1;
        owned = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            bus.req_valid = 1'b0;
            #1;
            if (bus.bus_busy_out) begin
                owned = 1'b1;
                break;
            end
        end
        `CHK("rstfill_owned", owned, 1);
        bus.mem_data_valid = 1'b1;
        bus.mem_data = 32'hDEAD_BEEF;
        reset = 1'b0;
        #1;
        `CHK("rstfill_drop_busy", bus.bus_busy_out, 0);
        `CHK("rstfill_drop_en", bus.mem_en, 0);
        `CHK("rstfill_no_done", bus.mem_done, 0);
        `CHK("rstfill_idle", bus.req_ready, 1);
        bus.mem_data_valid = 1'b0;
        cyc();
        reset = 1'b1;
        model_clear();
        access(32'h0000_1230, 0, 0, 0, 0);
        access(32'h0000_1230, 1, 0, 0, 0);

`ifdef ICACHE_STATS_EN
        `CHK("stats_hits", hit_count, m_hits);
        `CHK("stats_misses", miss_count, m_misses);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
